i2c_byte_tx: RTL and testbench

Byte-level I2C transmit sequencer. It frames one byte per request as START, 8 data bits, ACK slot and STOP, producing one SDA bit per clk cycle. It sits directly upstream of the existing 3-bit bit counter (module `counter`). It drives that counter's `newcount` and consumes its `outcount` to find the last data bit, instead of keeping its own bit count. SCL generation and the open-drain pad live in the parent.

---
 rtl/i2c_byte_tx_pkg.sv | 20 ++
 rtl/counter.sv | 38 +++
 rtl/i2c_byte_tx.sv | 110 +++++++++++
 tb/tb_i2c_byte_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_byte_tx_pkg.sv
// i2c_byte_tx_pkg
//   Shared definitions for the byte-level I2C transmit sequencer:
//   FSM state encodings, SDA drive levels and the byte width.
package i2c_byte_tx_pkg;

    localparam int BYTE_W = 8;

    // Open-drain view of SDA: 1 lets the pull-up win, 0 pulls the line low.
    localparam logic SDA_RELEASE   = 1'b1;
    localparam logic SDA_DRIVE_LOW = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4
    } state_t;

endpackage

// File: rtl/counter.sv
// counter
//   3-bit bit counter that sits beside i2c_byte_tx. A newcount pulse clears
//   the count to 0 and enables counting. The count then advances once per
//   clk and parks at 7 after that cycle.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   newcount  restart request (clear to 0 and enable)
//   outcount  high while enabled and the count is 7
module counter (
    input  logic clk,
    input  logic rst,
    input  logic newcount,
    output logic outcount
);

    logic [2:0] count;
    logic       en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 3'd0;
            en    <= 1'b0;
        end else if (newcount) begin
            count <= 3'd0;
            en    <= 1'b1;
        end else if (en) begin
            if (count == 3'd7) begin
                en <= 1'b0;
            end else begin
                count <= count + 3'd1;
            end
        end
    end

    assign outcount = en && (count == 3'd7);

endmodule

// File: rtl/i2c_byte_tx.sv
// i2c_byte_tx
//   Byte-level I2C transmit sequencer. Each accepted request is framed as
//   START, 8 data bits, ACK slot and STOP, with one SDA bit per clk cycle.
//   The bit position inside DATA comes from the external `counter`: this
//   block restarts it with newcount in START and leaves DATA when outcount
//   flags the 8th bit.
// Ports:
//   clk       system clock, one bit slot per cycle
//   rst       asynchronous active-low reset
//   start     transmit request, only looked at in IDLE
//   din       byte to send, captured when start is accepted
//   sda_in    SDA line level, sampled at the end of the ACK slot
//   outcount  from counter: high in the cycle carrying the 8th data bit
//   newcount  to counter: restart the bit count
//   sda_out   SDA drive value (0 = pull low, 1 = release)
//   busy      high from start acceptance until the return to IDLE
//   done      one-cycle pulse in the first IDLE cycle after STOP
//   ack_err   slave NACKed the last byte; held until the next accepted start
//
// state | meaning
// IDLE  | SDA released, waiting for start
// START | SDA low for the START condition, counter restarted
// DATA  | shifting out the 8 data bits
// ACK   | SDA released so the slave can acknowledge
// STOP  | SDA low; the following IDLE cycle releases it for the STOP edge
module i2c_byte_tx
    import i2c_byte_tx_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] din,
    input  logic              sda_in,
    input  logic              outcount,
    output logic              newcount,
    output logic              sda_out,
    output logic              busy,
    output logic              done,
    output logic              ack_err
);

    state_t            state;
    logic [BYTE_W-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= din;
                        ack_err <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    state <= DATA;
                end
                DATA: begin
                    // The outcount cycle carries the 8th bit, so no shift on exit.
                    if (outcount) begin
                        state <= ACK;
                    end else if (MSB_FIRST) begin
                        shreg <= {shreg[BYTE_W-2:0], 1'b0};
                    end else begin
                        shreg <= {1'b0, shreg[BYTE_W-1:1]};
                    end
                end
                ACK: begin
                    ack_err <= sda_in;
                    state   <= STOP;
                end
                STOP: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sda_out  = SDA_RELEASE;
        newcount = 1'b0;
        case (state)
            START: begin
                sda_out  = SDA_DRIVE_LOW;
                newcount = 1'b1;
            end
            DATA:    sda_out = MSB_FIRST ? shreg[BYTE_W-1] : shreg[0];
            ACK:     sda_out = SDA_RELEASE;
            STOP:    sda_out = SDA_DRIVE_LOW;
            default: sda_out = SDA_RELEASE;
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_tx.sv
module tb_i2c_byte_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       sda_in;

    logic nc_m, oc_m, sda_m, busy_m, done_m, ack_m;
    logic nc_l, oc_l, sda_l, busy_l, done_l, ack_l;

    int checks   = 0;
    int failures = 0;

    // MSB-first instance and its counter
    i2c_byte_tx #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .start(start), .din(din), .sda_in(sda_in),
        .outcount(oc_m), .newcount(nc_m), .sda_out(sda_m),
        .busy(busy_m), .done(done_m), .ack_err(ack_m)
    );
    counter cnt_m (.clk(clk), .rst(rst), .newcount(nc_m), .outcount(oc_m));

    // LSB-first instance and its counter
    i2c_byte_tx #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .din(din), .sda_in(sda_in),
        .outcount(oc_l), .newcount(nc_l), .sda_out(sda_l),
        .busy(busy_l), .done(done_l), .ack_err(ack_l)
    );
    counter cnt_l (.clk(clk), .rst(rst), .newcount(nc_l), .outcount(oc_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within a frame.
    //   0        idle
    //   1        START slot
    //   2..9     data bit (pos-2) in transmission order
    //   10       ACK slot
    //   11       STOP slot
    //   12       first idle cycle after STOP (done high, may accept)
    int         pos   = 0;
    logic [7:0] mbyte = 8'h00;
    logic       mack  = 1'b0;

    function automatic logic exp_sda(input int p, input logic [7:0] b, input bit msb);
        if (p == 1 || p == 11) return 1'b0;
        if (p >= 2 && p <= 9) return msb ? b[9-p] : b[p-2];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos  = 0;
            mack = 1'b0;
        end else if (pos == 0 || pos == 12) begin
            if (start) begin
                pos   = 1;
                mbyte = din;
                mack  = 1'b0;
            end else begin
                pos = 0;
            end
        end else begin
            if (pos == 10) mack = sda_in;
            pos = pos + 1;
        end
    end

    always @(negedge clk) begin
        chk("sda_m",      sda_m,  exp_sda(pos, mbyte, 1'b1));
        chk("sda_l",      sda_l,  exp_sda(pos, mbyte, 1'b0));
        chk("newcount_m", nc_m,   pos == 1);
        chk("newcount_l", nc_l,   pos == 1);
        chk("busy_m",     busy_m, pos >= 1 && pos <= 11);
        chk("busy_l",     busy_l, pos >= 1 && pos <= 11);
        chk("done_m",     done_m, pos == 12);
        chk("done_l",     done_l, pos == 12);
        chk("ack_err_m",  ack_m,  mack);
        chk("ack_err_l",  ack_l,  mack);
        if (pos >= 2 && pos <= 9) begin
            chk("outcount_m", oc_m, pos == 9);
            chk("outcount_l", oc_l, pos == 9);
        end
    end

    // Stimulus changes 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int exp1[12] = '{0, 1,0,1,0,0,1,0,1, 1, 0, 1};
    int exp6[12] = '{0, 1,0,0,0,0,0,0,1, 1, 0, 1};
    int done_at[$];
    int nc_cnt;

    initial begin
        rst = 1'b0; start = 1'b0; din = 8'h00; sda_in = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_sda",     sda_m,  1'b1);
        chk("rst_busy",    busy_m, 1'b0);
        chk("rst_done",    done_m, 1'b0);
        chk("rst_ack_err", ack_m,  1'b0);
        chk("rst_newcnt",  nc_m,   1'b0);
        rst = 1'b1;
        repeat (2) step();

        // 1: single byte A5, ACKed
        din = 8'hA5; sda_in = 1'b0; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) start = 1'b0;
            chk("t1_sda_m", sda_m, exp1[i]);
            chk("t1_sda_l", sda_l, exp1[i]);
            chk("t1_busy",  busy_m, i <= 10);
            chk("t1_done",  done_m, i == 11);
        end
        chk("t1_ack_err", ack_m, 1'b0);
        repeat (2) step();

        // 2: NACK, then ack_err clears on the next accepted start
        din = 8'h3C; sda_in = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        repeat (3) step();
        chk("t2_ack_err_hold_m", ack_m, 1'b1);
        chk("t2_ack_err_hold_l", ack_l, 1'b1);
        sda_in = 1'b0; din = 8'h96; start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_ack_err_clear", ack_m, 1'b0);
        repeat (12) step();

        // 3: LSB-first 01
        din = 8'h01; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (i >= 1 && i <= 8) begin
                chk("t3_bit_l",      sda_l, i == 1);
                chk("t3_bit_m",      sda_m, i == 8);
                chk("t3_outcount_l", oc_l,  i == 8);
            end
        end
        repeat (2) step();

        // 4: back-to-back FF then 00 with start held high
        din = 8'hFF; start = 1'b1; nc_cnt = 0;
        done_at.delete();
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 0) din = 8'h00;
            if (i == 12) begin
                chk("t4_nogap_sda", sda_m, 1'b0);
                start = 1'b0;
            end
            if (i >= 1 && i <= 8) chk("t4_ff_bit", sda_m, 1'b1);
            if (done_m) done_at.push_back(i);
            if (nc_m) nc_cnt++;
        end
        chk("t4_done_count", done_at.size(), 2);
        chk("t4_newcount_count", nc_cnt, 2);
        if (done_at.size() == 2) begin
            chk("t4_first_done", done_at[0], 11);
            chk("t4_done_spacing", done_at[1] - done_at[0], 12);
        end
        repeat (2) step();

        // 5: start pulse while busy is ignored
        din = 8'hF0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (i == 4) begin start = 1'b1; din = 8'h55; end
            if (i == 5) start = 1'b0;
            if (i >= 1 && i <= 8) chk("t5_f0_bit", sda_m, i <= 4);
            if (i >= 12) chk("t5_no_extra", busy_m, 1'b0);
        end

        // 6: reset during DATA cycle 5, then resync
        din = 8'($urandom); start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) start = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("t6_rst_sda_m", sda_m,  1'b1);
        chk("t6_rst_sda_l", sda_l,  1'b1);
        chk("t6_rst_busy",  busy_m, 1'b0);
        chk("t6_rst_done",  done_m, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        step();
        din = 8'h81; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) start = 1'b0;
            chk("t6_sda_m", sda_m, exp6[i]);
            chk("t6_sda_l", sda_l, exp6[i]);
            chk("t6_newcount", nc_m, i == 0);
            if (i >= 1 && i <= 8) chk("t6_outcount", oc_m, i == 8);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            start  = ($urandom_range(0, 3) == 0);
            din    = 8'($urandom);
            sda_in = 1'($urandom);
            rst    = ($urandom_range(0, 150) != 0);
            step();
        end
        rst = 1'b1; start = 1'b0;
        repeat (15) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
